// File: rtl/demux2_buf.sv
// demux2_buf: one upstream stream steered by i_sel into two independent
// single-entry output channels (A and B), each with a wrapping delivery
// counter. A stalled channel never blocks traffic routed to its peer.
module demux2_buf #(
   parameter int P_WIDTH = 32,
   parameter int P_CNT_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   input  logic [P_WIDTH-1:0] i_data,
   input  logic               i_sel,
   output logic               o_ready,
   output logic               o_valid_a,
   output logic [P_WIDTH-1:0] o_data_a,
   input  logic               i_ready_a,
   output logic               o_valid_b,
   output logic [P_WIDTH-1:0] o_data_b,
   input  logic               i_ready_b,
   output logic [P_CNT_W-1:0] o_cnt_a,
   output logic [P_CNT_W-1:0] o_cnt_b
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } chan_state_t;

   localparam logic [P_CNT_W-1:0] CNT_ONE  = {{(P_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [P_CNT_W-1:0] CNT_ZERO = {P_CNT_W{1'b0}};
   localparam logic [P_WIDTH-1:0] DATA_ZERO = {P_WIDTH{1'b0}};

   chan_state_t        state_a_r, state_a_s;
   chan_state_t        state_b_r, state_b_s;
   logic [P_WIDTH-1:0] data_a_r, data_a_s;
   logic [P_WIDTH-1:0] data_b_r, data_b_s;
   logic [P_CNT_W-1:0] cnt_a_r, cnt_a_s;
   logic [P_CNT_W-1:0] cnt_b_r, cnt_b_s;

   logic drain_a_s, drain_b_s;
   logic ready_s;
   logic acc_a_s, acc_b_s;
   logic dlv_a_s, dlv_b_s;

   // Handshake decode: drainable conditions, upstream ready, accepts and deliveries.
   always_comb begin
      drain_a_s = 1'b0;
      drain_b_s = 1'b0;
      ready_s   = 1'b0;
      if (state_a_r == ST_EMPTY) begin
         drain_a_s = 1'b1;
      end else begin
         drain_a_s = i_ready_a;
      end
      if (state_b_r == ST_EMPTY) begin
         drain_b_s = 1'b1;
      end else begin
         drain_b_s = i_ready_b;
      end
      // Ready depends only on the selected channel, never on i_valid.
      if (i_sel) begin
         ready_s = drain_b_s;
      end else begin
         ready_s = drain_a_s;
      end
      acc_a_s = i_valid & ready_s & ~i_sel;
      acc_b_s = i_valid & ready_s & i_sel;
      dlv_a_s = (state_a_r == ST_FULL) & i_ready_a;
      dlv_b_s = (state_b_r == ST_FULL) & i_ready_b;
   end

   // Channel A next state: load on accept (even while delivering), empty on delivery alone.
   always_comb begin
      state_a_s = state_a_r;
      data_a_s  = data_a_r;
      case (state_a_r)
         ST_EMPTY: begin
            if (acc_a_s) begin
               state_a_s = ST_FULL;
               data_a_s  = i_data;
            end else begin
               state_a_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (acc_a_s) begin
               state_a_s = ST_FULL;
               data_a_s  = i_data;
            end else if (dlv_a_s) begin
               state_a_s = ST_EMPTY;
            end else begin
               state_a_s = ST_FULL;
            end
         end
         default: begin
            state_a_s = ST_EMPTY;
         end
      endcase
   end

   // Channel B next state: mirror of channel A with its own handshake.
   always_comb begin
      state_b_s = state_b_r;
      data_b_s  = data_b_r;
      case (state_b_r)
         ST_EMPTY: begin
            if (acc_b_s) begin
               state_b_s = ST_FULL;
               data_b_s  = i_data;
            end else begin
               state_b_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (acc_b_s) begin
               state_b_s = ST_FULL;
               data_b_s  = i_data;
            end else if (dlv_b_s) begin
               state_b_s = ST_EMPTY;
            end else begin
               state_b_s = ST_FULL;
            end
         end
         default: begin
            state_b_s = ST_EMPTY;
         end
      endcase
   end

   // Delivery counters: count completed output handshakes, wrapping naturally.
   always_comb begin
      if (dlv_a_s) begin
         cnt_a_s = cnt_a_r + CNT_ONE;
      end else begin
         cnt_a_s = cnt_a_r;
      end
      if (dlv_b_s) begin
         cnt_b_s = cnt_b_r + CNT_ONE;
      end else begin
         cnt_b_s = cnt_b_r;
      end
   end

   // State registers: reset discards held words and clears counters at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_a_r <= ST_EMPTY;
         state_b_r <= ST_EMPTY;
         data_a_r  <= DATA_ZERO;
         data_b_r  <= DATA_ZERO;
         cnt_a_r   <= CNT_ZERO;
         cnt_b_r   <= CNT_ZERO;
      end else begin
         state_a_r <= state_a_s;
         state_b_r <= state_b_s;
         data_a_r  <= data_a_s;
         data_b_r  <= data_b_s;
         cnt_a_r   <= cnt_a_s;
         cnt_b_r   <= cnt_b_s;
      end
   end

   assign o_ready   = ready_s;
   assign o_valid_a = (state_a_r == ST_FULL);
   assign o_valid_b = (state_b_r == ST_FULL);
   assign o_data_a  = data_a_r;
   assign o_data_b  = data_b_r;
   assign o_cnt_a   = cnt_a_r;
   assign o_cnt_b   = cnt_b_r;

endmodule

// File: tb/tb_demux2_buf.sv
// Self-checking bench for demux2_buf: scoreboard queues per channel hold the
// words expected to be delivered, filled when the bench predicts an accept and
// drained by a monitor on every observed delivery.
module tb_demux2_buf;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_valid;
   logic [W-1:0]  i_data;
   logic          i_sel;
   logic          o_ready;
   logic          o_valid_a;
   logic [W-1:0]  o_data_a;
   logic          i_ready_a;
   logic          o_valid_b;
   logic [W-1:0]  o_data_b;
   logic          i_ready_b;
   logic [CW-1:0] o_cnt_a;
   logic [CW-1:0] o_cnt_b;

   int n_cmp  = 0;
   int n_fail = 0;

   // bench-side reference state
   bit            m_full_a, m_full_b;
   logic [CW-1:0] m_cnt_a, m_cnt_b;
   logic [W-1:0]  q_a[$];
   logic [W-1:0]  q_b[$];

   demux2_buf #(.P_WIDTH(W), .P_CNT_W(CW)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_sel     (i_sel),
      .o_ready   (o_ready),
      .o_valid_a (o_valid_a),
      .o_data_a  (o_data_a),
      .i_ready_a (i_ready_a),
      .o_valid_b (o_valid_b),
      .o_data_b  (o_data_b),
      .i_ready_b (i_ready_b),
      .o_cnt_a   (o_cnt_a),
      .o_cnt_b   (o_cnt_b)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Scoreboard monitor: every delivery must match the oldest expected word.
   always @(negedge i_clk) begin
      logic [W-1:0] exp_w;
      if (i_rst_n) begin
         if (o_valid_a && i_ready_a) begin
            n_cmp++;
            if (q_a.size() == 0) begin
               n_fail++;
               $display("FAIL sb_a: unexpected word %h, required none", o_data_a);
            end else begin
               exp_w = q_a.pop_front();
               if (o_data_a !== exp_w) begin
                  n_fail++;
                  $display("FAIL sb_a: got %h required %h", o_data_a, exp_w);
               end
            end
         end
         if (o_valid_b && i_ready_b) begin
            n_cmp++;
            if (q_b.size() == 0) begin
               n_fail++;
               $display("FAIL sb_b: unexpected word %h, required none", o_data_b);
            end else begin
               exp_w = q_b.pop_front();
               if (o_data_b !== exp_w) begin
                  n_fail++;
                  $display("FAIL sb_b: got %h required %h", o_data_b, exp_w);
               end
            end
         end
      end
   end

   // One clock cycle: predict accept/delivery from current inputs, then advance.
   task automatic tick();
      bit           dl_a, dl_b, acc;
      logic         sel;
      logic [W-1:0] d;
      dl_a = m_full_a && i_ready_a;
      dl_b = m_full_b && i_ready_b;
      sel  = i_sel;
      d    = i_data;
      acc  = i_valid && (sel ? (!m_full_b || i_ready_b) : (!m_full_a || i_ready_a));
      @(posedge i_clk);
      #1;
      if (i_rst_n) begin
         if (dl_a) m_cnt_a = m_cnt_a + 4'd1;
         if (dl_b) m_cnt_b = m_cnt_b + 4'd1;
         if (acc && !sel) begin
            m_full_a = 1'b1;
            q_a.push_back(d);
         end else if (dl_a) begin
            m_full_a = 1'b0;
         end
         if (acc && sel) begin
            m_full_b = 1'b1;
            q_b.push_back(d);
         end else if (dl_b) begin
            m_full_b = 1'b0;
         end
      end
   endtask

   task automatic model_clear();
      m_full_a = 1'b0;
      m_full_b = 1'b0;
      m_cnt_a  = 4'd0;
      m_cnt_b  = 4'd0;
      q_a.delete();
      q_b.delete();
   endtask

   // Pulse reset between clock edges; release also between edges.
   task automatic do_reset();
      #2;
      i_rst_n = 1'b0;
      model_clear();
      #2;
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_valid = 1'b0; i_sel = 1'b0; i_data = 32'h0;
      i_ready_a = 1'b0; i_ready_b = 1'b0;
      i_rst_n = 1'b0;
      model_clear();
      #3;
      n_cmp++;
      if ({o_valid_a, o_valid_b} !== 2'b00 || o_data_a !== 32'h0 || o_data_b !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_out: va=%b vb=%b da=%h db=%h required 0", o_valid_a, o_valid_b, o_data_a, o_data_b);
      end
      n_cmp++;
      if (o_cnt_a !== 4'd0 || o_cnt_b !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: a=%0d b=%0d required 0", o_cnt_a, o_cnt_b);
      end
      for (int s = 0; s < 2; s++) begin
         i_sel = s[0];
         #1;
         n_cmp++;
         if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready sel=%0d: got %b required 1", s, o_ready);
         end
      end
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   task automatic test_basic();
      i_valid = 1'b1; i_sel = 1'b0; i_data = 32'h11111111; i_ready_a = 1'b1;
      tick();
      i_valid = 1'b0;
      n_cmp++;
      if (o_valid_a !== 1'b1 || o_data_a !== 32'h11111111 || o_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_load: va=%b da=%h vb=%b required 1/11111111/0", o_valid_a, o_data_a, o_valid_b);
      end
      tick();
      n_cmp++;
      if (o_cnt_a !== 4'd1 || o_valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_deliver: cnt_a=%0d va=%b required 1/0", o_cnt_a, o_valid_a);
      end
   endtask

   task automatic test_stall_no_block();
      i_ready_a = 1'b0; i_ready_b = 1'b0;
      i_valid = 1'b1; i_sel = 1'b0; i_data = 32'hAAAA0000;
      tick();
      i_data = 32'hAAAA0001;
      #1;
      n_cmp++;
      if (o_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_ready: got %b required 0", o_ready);
      end
      i_valid = 1'b0;
      #1;
      n_cmp++;
      if (o_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_ready_novalid: got %b required 0", o_ready);
      end
      i_valid = 1'b1;
      tick();
      n_cmp++;
      if (o_valid_a !== 1'b1 || o_data_a !== 32'hAAAA0000) begin
         n_fail++;
         $display("FAIL stall_hold: va=%b da=%h required 1/aaaa0000", o_valid_a, o_data_a);
      end
      i_sel = 1'b1; i_data = 32'hBBBB0000;
      #1;
      n_cmp++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL other_ready: got %b required 1", o_ready);
      end
      tick();
      i_valid = 1'b0;
      n_cmp++;
      if (o_valid_b !== 1'b1 || o_data_b !== 32'hBBBB0000 || o_data_a !== 32'hAAAA0000) begin
         n_fail++;
         $display("FAIL other_load: vb=%b db=%h da=%h required 1/bbbb0000/aaaa0000", o_valid_b, o_data_b, o_data_a);
      end
      // idle inputs with i_valid low must not disturb held words
      i_sel = 1'b0; i_data = 32'hDEADBEEF;
      tick();
      n_cmp++;
      if (o_data_a !== 32'hAAAA0000 || o_data_b !== 32'hBBBB0000 || !o_valid_a || !o_valid_b) begin
         n_fail++;
         $display("FAIL idle_hold: da=%h db=%h required aaaa0000/bbbb0000", o_data_a, o_data_b);
      end
      // both deliver in the same cycle
      i_ready_a = 1'b1; i_ready_b = 1'b1;
      tick();
      n_cmp++;
      if (o_valid_a !== 1'b0 || o_valid_b !== 1'b0 || o_cnt_a !== m_cnt_a || o_cnt_b !== m_cnt_b) begin
         n_fail++;
         $display("FAIL dual_deliver: va=%b vb=%b ca=%0d cb=%0d required 0/0/%0d/%0d", o_valid_a, o_valid_b, o_cnt_a, o_cnt_b, m_cnt_a, m_cnt_b);
      end
   endtask

   task automatic test_replace();
      logic [CW-1:0] prev;
      i_ready_a = 1'b0; i_valid = 1'b1; i_sel = 1'b0; i_data = 32'h1;
      tick();
      prev = m_cnt_a;
      i_ready_a = 1'b1; i_data = 32'h2;
      #1;
      n_cmp++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL replace_ready: got %b required 1", o_ready);
      end
      tick();
      i_valid = 1'b0;
      n_cmp++;
      if (o_valid_a !== 1'b1 || o_data_a !== 32'h2 || o_cnt_a !== prev + 4'd1) begin
         n_fail++;
         $display("FAIL replace: va=%b da=%h cnt=%0d required 1/2/%0d", o_valid_a, o_data_a, o_cnt_a, prev + 4'd1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_ready_a = 1'b1; i_ready_b = 1'b1; i_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_sel  = i[0];
         i_data = 32'hC0DE0000 + i;
         #1;
         n_cmp++;
         if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ready[%0d]: got %b required 1", i, o_ready);
         end
         tick();
      end
      i_valid = 1'b0;
      tick();
      n_cmp++;
      if (o_cnt_a !== 4'd4 || o_cnt_b !== 4'd4) begin
         n_fail++;
         $display("FAIL stream_cnt: a=%0d b=%0d required 4/4", o_cnt_a, o_cnt_b);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      i_ready_b = 1'b1; i_valid = 1'b1; i_sel = 1'b1;
      for (int i = 0; i < 17; i++) begin
         i_data = 32'hB0000000 + i;
         tick();
      end
      i_valid = 1'b0;
      tick();
      n_cmp++;
      if (o_cnt_b !== 4'd1 || o_cnt_a !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap: cnt_b=%0d cnt_a=%0d required 1/0", o_cnt_b, o_cnt_a);
      end
   endtask

   task automatic test_reset_mid();
      i_ready_a = 1'b0; i_ready_b = 1'b0; i_valid = 1'b1;
      i_sel = 1'b0; i_data = 32'h0000A5A5;
      tick();
      i_sel = 1'b1; i_data = 32'h0000B5B5;
      tick();
      i_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      model_clear();
      #1;
      n_cmp++;
      if (o_valid_a !== 1'b0 || o_valid_b !== 1'b0 || o_cnt_a !== 4'd0 || o_cnt_b !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_mid: va=%b vb=%b ca=%0d cb=%0d required 0", o_valid_a, o_valid_b, o_cnt_a, o_cnt_b);
      end
      #1;
      i_rst_n = 1'b1;
      i_valid = 1'b1; i_sel = 1'b1; i_data = 32'h5;
      tick();
      i_valid = 1'b0;
      n_cmp++;
      if (o_valid_b !== 1'b1 || o_data_b !== 32'h5 || o_cnt_b !== 4'd0) begin
         n_fail++;
         $display("FAIL post_reset_load: vb=%b db=%h cb=%0d required 1/5/0", o_valid_b, o_data_b, o_cnt_b);
      end
      tick();
      n_cmp++;
      if (o_cnt_b !== 4'd0 || o_valid_b !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_hold: cb=%0d vb=%b required 0/1", o_cnt_b, o_valid_b);
      end
      i_ready_b = 1'b1;
      tick();
      n_cmp++;
      if (o_cnt_b !== 4'd1 || o_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_deliver: cb=%0d vb=%b required 1/0", o_cnt_b, o_valid_b);
      end
   endtask

   task automatic test_drained();
      i_valid = 1'b0; i_ready_a = 1'b1; i_ready_b = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_fail++;
         $display("FAIL undelivered: qa=%0d qb=%0d required 0/0", q_a.size(), q_b.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_no_block();
      test_replace();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_drained();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 SHALL have parameter P_WIDTH, default 32, giving the data bus width in bits.
REQ-002 SHALL have parameter P_CNT_W, default 16, giving the width of each transfer counter.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous assertion and release, active-low.
REQ-005 i_valid  input  1  upstream word present.
REQ-006 i_data  input  P_WIDTH  upstream word.
REQ-007 i_sel  input  1  destination of the current word; 0 routes to channel A, 1 to channel B; sampled with i_data.
REQ-008 o_ready  output  1  upstream word accepted this cycle when high with i_valid.
REQ-009 o_valid_a / o_data_a  output  1 / P_WIDTH  channel A word present / word.
REQ-010 i_ready_a  input  1  channel A consumer accepts.
REQ-011 o_valid_b / o_data_b  output  1 / P_WIDTH  channel B word present / word.
REQ-012 i_ready_b  input  1  channel B consumer accepts.
REQ-013 o_cnt_a / o_cnt_b  output  P_CNT_W  count of words delivered on channel A / channel B.

Function
REQ-014 Each channel SHALL hold a single-entry register with state EMPTY or FULL; o_valid_x SHALL be 1 exactly when channel x is FULL.
REQ-015 o_data_x SHALL drive the held word while FULL and SHALL remain stable until the word is delivered.
REQ-016 Channel x SHALL be drainable in a cycle when it is EMPTY, or when it is FULL and i_ready_x=1.
REQ-017 o_ready SHALL equal the drainable condition of the channel selected by the current i_sel (combinational on i_sel, channel state and i_ready_x); it SHALL NOT depend on i_valid.
REQ-018 An accept SHALL occur when i_valid=1 and o_ready=1; the accepted word SHALL be loaded into the selected channel at that rising edge; latency input to o_valid_x SHALL be 1 cycle.
REQ-019 A delivery on channel x SHALL occur when o_valid_x=1 and i_ready_x=1.
REQ-020 Channel transitions: EMPTY→FULL on accept; FULL→EMPTY on delivery without accept; FULL→FULL with new data on simultaneous delivery and accept; otherwise hold.
REQ-021 A full channel SHALL NOT block the other channel: accepts to the non-selected channel proceed independently of its peer's state.
REQ-022 Both channels SHALL deliver independently in the same cycle when both handshakes complete.
REQ-023 Sustained throughput SHALL be one word per cycle into a channel whose consumer holds i_ready_x=1.
REQ-024 o_cnt_x SHALL increment by 1 on each delivery on channel x and SHALL wrap from 2^P_CNT_W-1 to 0.
REQ-025 Words SHALL never be duplicated, dropped or reordered within a channel.
REQ-026 When i_valid=0, i_sel and i_data SHALL have no effect on state.

Reset
REQ-027 While i_rst_n=0: both channels EMPTY, o_valid_a=o_valid_b=0, o_data_a=o_data_b=0, o_cnt_a=o_cnt_b=0, independent of i_clk.
REQ-028 Assertion of reset mid-operation SHALL immediately discard any held words; no delivery counts for the cycle of reset assertion.
REQ-029 After release, the first accept SHALL be possible on the first rising edge with i_rst_n=1; o_ready during reset SHALL equal 1 (channels EMPTY).

Verification
REQ-030 Reset, then i_valid=1, i_sel=0, i_data=0x11111111, i_ready_a=1 for one cycle -> next cycle o_valid_a=1, o_data_a=0x11111111, o_valid_b=0; following cycle o_cnt_a=1, o_valid_a=0.
REQ-031 Load channel A with 0xAAAA0000 while i_ready_a=0; then i_sel=0 word 0xAAAA0001 -> o_ready=0, o_data_a holds 0xAAAA0000; switch i_sel=1 with 0xBBBB0000 -> o_ready=1, channel B loads while A stays stalled.
REQ-032 Channel A FULL with 0x1, i_ready_a=1, accept 0x2 to A same cycle -> next cycle o_valid_a=1, o_data_a=0x2, o_cnt_a incremented by 1.
REQ-033 Streaming 8 words alternating i_sel 0/1, both ready tied high -> o_ready=1 every cycle, each channel outputs its 4 words in order, o_cnt_a=o_cnt_b=4.
REQ-034 P_CNT_W=4, deliver 17 words on channel B -> o_cnt_b=1; o_cnt_a=0.
REQ-035 Both channels FULL, assert i_rst_n=0 between clock edges -> o_valid_a=o_valid_b=0 and counters 0 immediately; after release, a new word 0x5 to B appears one cycle later with o_cnt_b=0 until delivered.
